// File: rtl/fp_cvt_writeback_pkg.sv
// Shared FP conversion definitions: integer format encodings, RISC-V saturation
// bounds, occupancy encoding and the skid-buffer entry layout.
package fp_cvt_writeback_pkg;

  localparam int CVT_DATA_W = 64;
  localparam int CVT_TAG_W  = 5;

  typedef enum logic [1:0] {
    FMT_I32 = 2'b00,
    FMT_U32 = 2'b01,
    FMT_I64 = 2'b10,
    FMT_U64 = 2'b11
  } fmt_e;

  // 32-bit bounds are stored already sign-extended to the 64-bit register width
  localparam logic [63:0] I32_MAX = 64'h0000_0000_7FFF_FFFF;
  localparam logic [63:0] I32_MIN = 64'hFFFF_FFFF_8000_0000;
  localparam logic [63:0] U32_MAX = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] U32_MIN = 64'h0000_0000_0000_0000;
  localparam logic [63:0] I64_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] I64_MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] U64_MAX = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] U64_MIN = 64'h0000_0000_0000_0000;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [CVT_DATA_W-1:0] data;
    logic [CVT_TAG_W-1:0]  tag;
    logic                  nv;
  } skid_entry_t;

endpackage

// File: rtl/fp_cvt_writeback_if.sv
// Handshake and data bundle between the FP-to-int converter, the writeback
// stage and the integer writeback port.
interface fp_cvt_writeback_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 5
);

  logic                  in_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_flg_NV;
  logic                  in_sign;
  logic                  in_is_nan;
  logic [1:0]            in_output_fmt;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  in_flush;
  logic                  in_fflags_clr;
  logic                  out_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_nv;
  logic                  out_fflags_NV;

  modport slave (
    input  in_valid, in_data, in_flg_NV, in_sign, in_is_nan, in_output_fmt,
           in_tag, in_flush, in_fflags_clr, in_ready,
    output out_ready, out_valid, out_data, out_tag, out_nv, out_fflags_NV
  );

  modport master (
    output in_valid, in_data, in_flg_NV, in_sign, in_is_nan, in_output_fmt,
           in_tag, in_flush, in_fflags_clr, in_ready,
    input  out_ready, out_valid, out_data, out_tag, out_nv, out_fflags_NV
  );

endinterface

// File: rtl/fp_cvt_saturate.sv
// Combinational invalid-flag derivation, RISC-V saturation and 32-bit sign
// extension of a raw conversion result.
module fp_cvt_saturate
  import fp_cvt_writeback_pkg::*;
(
  input  logic [63:0] data,
  input  logic        flg_nv,
  input  logic        sign,
  input  logic        is_nan,
  input  logic [1:0]  fmt,
  output logic [63:0] result,
  output logic        nv
);

  fmt_e fmt_q;
  logic is_unsigned;
  logic is_narrow;
  logic use_max;

  function automatic logic [63:0] sat_bound(input fmt_e f, input logic hi);
    logic [63:0] b;
    case (f)
      FMT_I32: b = hi ? I32_MAX : I32_MIN;
      FMT_U32: b = hi ? U32_MAX : U32_MIN;
      FMT_I64: b = hi ? I64_MAX : I64_MIN;
      default: b = hi ? U64_MAX : U64_MIN;
    endcase
    return b;
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

  assign fmt_q       = fmt_e'(fmt);
  assign is_unsigned = fmt[0];
  assign is_narrow   = ~fmt[1];
  // NaN always saturates high; only a genuinely negative operand picks the low bound
  assign use_max     = is_nan | ~sign;

  always_comb begin
    nv = flg_nv | (is_unsigned & sign & (|data));
    if (nv) begin
      result = sat_bound(fmt_q, use_max);
    end else if (is_narrow) begin
      result = sext32(data[31:0]);
    end else begin
      result = data;
    end
  end

endmodule

// File: rtl/fp_cvt_writeback.sv
// FP-to-int writeback stage: saturates/sign-extends converter results, holds
// them in a 2-entry skid buffer and accumulates the sticky NV exception flag.
module fp_cvt_writeback
  import fp_cvt_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 5
) (
  input logic                 clk,
  input logic                 rst,
  fp_cvt_writeback_if.slave   bus
);

  if (DATA_WIDTH != CVT_DATA_W || TAG_WIDTH != CVT_TAG_W) begin : g_bad_cfg
    $error("fp_cvt_writeback supports only DATA_WIDTH=64 and TAG_WIDTH=5");
  end

  logic [63:0] sat_data_p0;
  logic        sat_nv_p0;
  skid_entry_t entry_p0;

  skid_entry_t head_p1;
  skid_entry_t skid_p1;
  occ_e        occ_p1;
  logic        sticky_p1;

  skid_entry_t head_nxt;
  skid_entry_t skid_nxt;
  occ_e        occ_nxt;
  logic        sticky_nxt;

  logic push;
  logic pop;

  // ---- p0: combinational result formatting on the input side ----
  fp_cvt_saturate u_sat (
    .data   (bus.in_data),
    .flg_nv (bus.in_flg_NV),
    .sign   (bus.in_sign),
    .is_nan (bus.in_is_nan),
    .fmt    (bus.in_output_fmt),
    .result (sat_data_p0),
    .nv     (sat_nv_p0)
  );

  assign entry_p0 = '{data: sat_data_p0, tag: bus.in_tag, nv: sat_nv_p0};

  // out_ready comes from registered occupancy only, so in_ready never reaches it
  assign bus.out_ready = (occ_p1 != OCC_FULL);
  assign bus.out_valid = (occ_p1 != OCC_EMPTY);

  assign push = bus.in_valid & bus.out_ready & ~bus.in_flush;
  assign pop  = bus.out_valid & bus.in_ready;

  always_comb begin
    occ_nxt    = occ_p1;
    head_nxt   = head_p1;
    skid_nxt   = skid_p1;
    sticky_nxt = sticky_p1;

    // Set is evaluated after clear so a retiring invalid result wins over a CSR clear
    if (bus.in_fflags_clr) begin
      sticky_nxt = 1'b0;
    end
    if (pop && head_p1.nv) begin
      sticky_nxt = 1'b1;
    end

    if (bus.in_flush) begin
      occ_nxt = OCC_EMPTY;
    end else begin
      case (occ_p1)
        OCC_EMPTY: begin
          if (push) begin
            head_nxt = entry_p0;
            occ_nxt  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_nxt = entry_p0;
          end else if (push) begin
            skid_nxt = entry_p0;
            occ_nxt  = OCC_FULL;
          end else if (pop) begin
            occ_nxt = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            head_nxt = skid_p1;
            occ_nxt  = OCC_ONE;
          end
        end
        default: begin
          occ_nxt = OCC_EMPTY;
        end
      endcase
    end
  end

  // ---- p1: buffer state, head entry and sticky flag ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_p1    <= OCC_EMPTY;
      head_p1   <= '0;
      sticky_p1 <= 1'b0;
    end else begin
      occ_p1    <= occ_nxt;
      head_p1   <= head_nxt;
      sticky_p1 <= sticky_nxt;
    end
  end

  // The skid slot is only read at FULL, after it has been written, so it needs no reset
  always_ff @(posedge clk) begin
    skid_p1 <= skid_nxt;
  end

  assign bus.out_data      = head_p1.data;
  assign bus.out_tag       = head_p1.tag;
  assign bus.out_nv        = head_p1.nv;
  assign bus.out_fflags_NV = sticky_p1;

endmodule

// File: tb/tb_fp_cvt_writeback.sv
// Self-checking bench for fp_cvt_writeback: directed vector table, hand-written
// handshake/flag sequences and a randomized run against a queue-based model.
module tb_fp_cvt_writeback;

  localparam int DW = 64;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_cvt_writeback_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  fp_cvt_writeback #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  fmt;
    logic [63:0] d;
    logic        flg;
    logic        sgn;
    logic        nan;
    logic [63:0] exp_d;
    logic        exp_nv;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        nv;
  } m_entry_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h, want 0x%016h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [1:0] fmt, input logic [63:0] d,
                       input logic flg, input logic sgn, input logic nan,
                       input logic [4:0] tag, input logic rdy, input logic fl,
                       input logic clr);
    bus.in_valid      = v;
    bus.in_output_fmt = fmt;
    bus.in_data       = d;
    bus.in_flg_NV     = flg;
    bus.in_sign       = sgn;
    bus.in_is_nan     = nan;
    bus.in_tag        = tag;
    bus.in_ready      = rdy;
    bus.in_flush      = fl;
    bus.in_fflags_clr = clr;
  endtask

  task automatic quiet(input logic rdy);
    drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0, rdy, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    quiet(1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Reference: {nv, result} derived directly from the RISC-V conversion rules
  function automatic logic [64:0] ref_result(input logic [1:0] fmt, input logic [63:0] d,
                                             input logic flg, input logic sgn, input logic nan);
    logic              nv;
    logic              negative;
    logic [63:0]       r;
    logic signed [31:0] lo;
    nv       = flg || ((fmt == 2'b01 || fmt == 2'b11) && sgn && d != 64'd0);
    negative = sgn && !nan;
    if (nv) begin
      case (fmt)
        2'b00:   r = negative ? 64'hFFFFFFFF80000000 : 64'h000000007FFFFFFF;
        2'b01:   r = negative ? 64'h0 : 64'hFFFFFFFFFFFFFFFF;
        2'b10:   r = negative ? 64'h8000000000000000 : 64'h7FFFFFFFFFFFFFFF;
        default: r = negative ? 64'h0 : 64'hFFFFFFFFFFFFFFFF;
      endcase
    end else if (fmt == 2'b00 || fmt == 2'b01) begin
      lo = d[31:0];
      r  = longint'(lo);
    end else begin
      r = d;
    end
    return {nv, r};
  endfunction

  vec_t     vecs[12];
  m_entry_t q[$];
  logic     m_sticky;

  initial begin
    logic exp_sticky;

    vecs[0]  = '{2'b00, 64'h0000000000001234, 1'b0, 1'b0, 1'b0, 64'h0000000000001234, 1'b0};
    vecs[1]  = '{2'b00, 64'h00000000FFFFFFFE, 1'b0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFE, 1'b0};
    vecs[2]  = '{2'b10, 64'h8000000000000000, 1'b1, 1'b1, 1'b1, 64'h7FFFFFFFFFFFFFFF, 1'b1};
    vecs[3]  = '{2'b01, 64'hFFFFFFFFFFFFFFFB, 1'b0, 1'b1, 1'b0, 64'h0000000000000000, 1'b1};
    vecs[4]  = '{2'b00, 64'h0000000012345678, 1'b1, 1'b1, 1'b0, 64'hFFFFFFFF80000000, 1'b1};
    vecs[5]  = '{2'b00, 64'h0000000012345678, 1'b1, 1'b0, 1'b0, 64'h000000007FFFFFFF, 1'b1};
    vecs[6]  = '{2'b01, 64'h0000000000000000, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b1};
    vecs[7]  = '{2'b11, 64'h0000000000000000, 1'b0, 1'b1, 1'b0, 64'h0000000000000000, 1'b0};
    vecs[8]  = '{2'b10, 64'h0000000000000001, 1'b1, 1'b1, 1'b0, 64'h8000000000000000, 1'b1};
    vecs[9]  = '{2'b11, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b0, 1'b0, 64'hDEADBEEFCAFEF00D, 1'b0};
    vecs[10] = '{2'b01, 64'h0000000080000001, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFF80000001, 1'b0};
    vecs[11] = '{2'b11, 64'h0000000000000005, 1'b1, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1};

    // Reset state, sampled while reset is held
    quiet(1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_ready", 64'(bus.out_ready), 64'd1);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_out_nv", 64'(bus.out_nv), 64'd0);
    check("rst_fflags", 64'(bus.out_fflags_NV), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Vector table: single push, observe head one cycle later, pop it
    exp_sticky = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].fmt, vecs[i].d, vecs[i].flg, vecs[i].sgn, vecs[i].nan,
            5'(i), 1'b1, 1'b0, 1'b0);
      tick();
      quiet(1'b1);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("vec%0d_data", i), bus.out_data, vecs[i].exp_d);
      check($sformatf("vec%0d_nv", i), 64'(bus.out_nv), 64'(vecs[i].exp_nv));
      check($sformatf("vec%0d_tag", i), 64'(bus.out_tag), 64'(i));
      check($sformatf("vec%0d_fflags", i), 64'(bus.out_fflags_NV), 64'(exp_sticky));
      @(posedge clk);
      #1;
      exp_sticky = exp_sticky | vecs[i].exp_nv;
    end
    @(negedge clk);
    check("vec_end_valid", 64'(bus.out_valid), 64'd0);
    check("vec_end_fflags", 64'(bus.out_fflags_NV), 64'(exp_sticky));

    // Backpressure: three back-to-back pushes with in_ready low
    reset_dut();
    drive(1'b1, 2'b10, 64'hAAAA0000AAAA0001, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_ready_empty", 64'(bus.out_ready), 64'd1);
    check("bp_valid_empty", 64'(bus.out_valid), 64'd0);
    tick();
    drive(1'b1, 2'b10, 64'hBBBB0000BBBB0002, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_head_a", bus.out_data, 64'hAAAA0000AAAA0001);
    check("bp_ready_one", 64'(bus.out_ready), 64'd1);
    tick();
    drive(1'b1, 2'b10, 64'hCCCC0000CCCC0003, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_ready_full", 64'(bus.out_ready), 64'd0);
    check("bp_head_a_held", bus.out_data, 64'hAAAA0000AAAA0001);
    tick();
    @(negedge clk);
    check("bp_ready_full2", 64'(bus.out_ready), 64'd0);
    check("bp_tag_a_held", 64'(bus.out_tag), 64'd1);
    tick();
    drive(1'b1, 2'b10, 64'hCCCC0000CCCC0003, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_retire_a", bus.out_data, 64'hAAAA0000AAAA0001);
    tick();
    @(negedge clk);
    check("bp_retire_b", bus.out_data, 64'hBBBB0000BBBB0002);
    check("bp_tag_b", 64'(bus.out_tag), 64'd2);
    check("bp_ready_after_pop", 64'(bus.out_ready), 64'd1);
    tick();
    quiet(1'b1);
    @(negedge clk);
    check("bp_retire_c", bus.out_data, 64'hCCCC0000CCCC0003);
    check("bp_tag_c", 64'(bus.out_tag), 64'd3);
    check("bp_valid_c", 64'(bus.out_valid), 64'd1);
    tick();
    @(negedge clk);
    check("bp_drained", 64'(bus.out_valid), 64'd0);

    // Sticky flag: clear and set in the same cycle, then clear alone
    reset_dut();
    drive(1'b1, 2'b10, 64'h0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("clrset_head_nv", 64'(bus.out_nv), 64'd1);
    check("clrset_head_data", bus.out_data, 64'h7FFFFFFFFFFFFFFF);
    tick();
    quiet(1'b0);
    @(negedge clk);
    check("clrset_set_wins", 64'(bus.out_fflags_NV), 64'd1);
    drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    quiet(1'b0);
    @(negedge clk);
    check("clr_only", 64'(bus.out_fflags_NV), 64'd0);

    // Flush at FULL with a retiring invalid head and an ignored push
    reset_dut();
    drive(1'b1, 2'b00, 64'h5, 1'b1, 1'b0, 1'b0, 5'd11, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b10, 64'h22, 1'b0, 1'b0, 1'b0, 5'd12, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b10, 64'h33, 1'b0, 1'b0, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("flush_pre_ready", 64'(bus.out_ready), 64'd0);
    tick();
    quiet(1'b0);
    @(negedge clk);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_ready", 64'(bus.out_ready), 64'd1);
    check("flush_pop_sets_fflags", 64'(bus.out_fflags_NV), 64'd1);

    // Asynchronous reset at FULL with the sticky flag set
    drive(1'b1, 2'b10, 64'h44, 1'b0, 1'b0, 1'b0, 5'd14, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 2'b10, 64'h55, 1'b0, 1'b0, 1'b0, 5'd15, 1'b0, 1'b0, 1'b0);
    tick();
    quiet(1'b0);
    @(negedge clk);
    check("arst_pre_ready", 64'(bus.out_ready), 64'd0);
    check("arst_pre_fflags", 64'(bus.out_fflags_NV), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_ready", 64'(bus.out_ready), 64'd1);
    check("arst_data", bus.out_data, 64'd0);
    check("arst_tag", 64'(bus.out_tag), 64'd0);
    check("arst_nv", 64'(bus.out_nv), 64'd0);
    check("arst_fflags", 64'(bus.out_fflags_NV), 64'd0);
    tick();
    rst = 1'b0;

    // Randomized traffic against the queue model
    q.delete();
    m_sticky = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      logic        rv, rdy, fl, clr, flg, sgn, nan, pop, push;
      logic [1:0]  fmt;
      logic [63:0] d;
      logic [4:0]  tag;
      logic [64:0] rr;
      rv  = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 1) == 1);
      fl  = ($urandom_range(0, 31) == 0);
      clr = ($urandom_range(0, 15) == 0);
      flg = ($urandom_range(0, 4) == 0);
      sgn = ($urandom_range(0, 1) == 1);
      nan = ($urandom_range(0, 9) == 0);
      fmt = 2'($urandom_range(0, 3));
      tag = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0:       d = 64'h0;
        1:       d = {32'($urandom), 32'($urandom)};
        2:       d = {32'h0, 32'($urandom)};
        default: d = {32'hFFFFFFFF, 32'($urandom)};
      endcase
      drive(rv, fmt, d, flg, sgn, nan, tag, rdy, fl, clr);
      @(negedge clk);
      check("rnd_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      check("rnd_ready", 64'(bus.out_ready), 64'(q.size() < 2));
      check("rnd_fflags", 64'(bus.out_fflags_NV), 64'(m_sticky));
      if (q.size() > 0) begin
        check("rnd_data", bus.out_data, q[0].data);
        check("rnd_tag", 64'(bus.out_tag), 64'(q[0].tag));
        check("rnd_nv", 64'(bus.out_nv), 64'(q[0].nv));
      end
      @(posedge clk);
      pop  = (q.size() > 0) && rdy;
      push = rv && (q.size() < 2) && !fl;
      if (clr) m_sticky = 1'b0;
      if (pop && q[0].nv) m_sticky = 1'b1;
      if (pop) void'(q.pop_front());
      if (fl) begin
        q.delete();
      end else if (push) begin
        rr = ref_result(fmt, d, flg, sgn, nan);
        q.push_back('{data: rr[63:0], tag: tag, nv: rr[64]});
      end
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_cvt_writeback.md
# fp_cvt_writeback

Registered writeback stage directly downstream of the FP-to-integer converter in the FP unit. It takes the converter's raw 64-bit result and invalid flag and applies RISC-V saturation for invalid conversions. It sign-extends 32-bit results to 64 bits and buffers results in a 2-entry skid buffer with a valid/ready handshake toward the integer writeback port. It also keeps the sticky NV bit of fflags, which is updated only when a result retires.

## Interface
Parameters:
- DATA_WIDTH, 64, result width; only 64 is supported.
- TAG_WIDTH, 5, destination-register tag width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- in_valid  input  1  upstream result valid.
- out_ready  output  1  stage can accept; equals (occupancy < 2).
- in_data  input  64  raw converter result.
- in_flg_NV  input  1  converter invalid flag.
- in_sign  input  1  sign of the source FP operand.
- in_is_nan  input  1  source operand is NaN (quiet or signalling).
- in_output_fmt  input  2  00 int32, 01 uint32, 10 int64, 11 uint64.
- in_tag  input  TAG_WIDTH  destination-register tag.
- in_flush  input  1  synchronous pipeline flush.
- in_fflags_clr  input  1  clear the sticky NV bit (CSR write).
- out_valid  output  1  head entry valid.
- in_ready  input  1  downstream accepts the head entry.
- out_data  output  64  final integer result.
- out_tag  output  TAG_WIDTH  tag of the head entry.
- out_nv  output  1  NV flag of the head entry.
- out_fflags_NV  output  1  sticky NV accumulator.

## Operation
- Effective invalid flag: nv = in_flg_NV | (in_output_fmt[0] & in_sign & (in_data != 0)).
  - The second term covers a negative non-zero value converted to an unsigned format.
- Saturation is applied when nv = 1:
  - A NaN or positive source selects MAX; a negative non-NaN source selects MIN.
  - int32: MAX 0x000000007FFFFFFF, MIN 0xFFFFFFFF80000000.
  - uint32: MAX 0xFFFFFFFFFFFFFFFF (0xFFFFFFFF sign-extended), MIN 0.
  - int64: MAX 0x7FFFFFFFFFFFFFFF, MIN 0x8000000000000000.
  - uint64: MAX 0xFFFFFFFFFFFFFFFF, MIN 0.
- When nv = 0:
  - 32-bit formats return {{32{in_data[31]}}, in_data[31:0]}.
  - 64-bit formats pass in_data through unchanged.
- Result formatting is combinational on the input side. Entries store the formatted data, the tag and nv.
- Buffer state machine, with occupancy counter occ in {EMPTY=0, ONE=1, FULL=2}:
  - push = in_valid & out_ready.
  - pop = out_valid & in_ready.
  - push only: occ+1. pop only: occ-1. push and pop together: occ unchanged.
  - FIFO order is strict: the head is the oldest entry.
  - A push and pop in the same cycle at ONE replaces the head with the new entry.
  - At FULL, out_ready = 0. A push is impossible and a pop moves the skid entry to the head.
- Sticky flag:
  - out_fflags_NV is set on any pop with head nv = 1.
  - in_fflags_clr clears it.
  - If clear and set occur in the same cycle, set wins.
- Flush:
  - in_flush empties the buffer (occ becomes EMPTY) and ignores any push in that cycle.
  - A pop in the flush cycle still retires and still updates the sticky flag.
  - The sticky flag is not cleared by flush.

## Timing
- Latency: 1 cycle. A push in cycle N gives out_valid in cycle N+1 when the buffer was empty.
- Throughput: 1 result per cycle while in_ready = 1.
- out_ready depends only on registered occ. There is no combinational path from in_ready to out_ready.
- Reset values:
  - occ = EMPTY, out_valid = 0, out_ready = 1.
  - out_data = 0, out_tag = 0, out_nv = 0, out_fflags_NV = 0.
- Reset asserted mid-operation discards all entries immediately (asynchronously).
- out_data, out_tag and out_nv are held stable while out_valid = 1 and in_ready = 0.

## Structure
- Shared FP package holds:
  - fmt encodings FMT_I32, FMT_U32, FMT_I64, FMT_U64;
  - the four MAX/MIN saturation constants;
  - the skid-entry struct {data, tag, nv}.
- One natural sub-module, fp_cvt_saturate: the combinational nv/saturation/sign-extension logic.
  - It is reused by the future int-to-int narrowing path.
- The buffer and sticky flag live in fp_cvt_writeback itself.

## Test plan
- int32, in_data=0x0000000000001234, nv=0, sign=0, one push with in_ready=1 -> next cycle out_valid=1, out_data=0x0000000000001234; out_fflags_NV stays 0.
- int32, in_data=0x00000000FFFFFFFE (-2), sign=1, nv=0 -> out_data=0xFFFFFFFFFFFFFFFE.
- int64, in_flg_NV=1, in_is_nan=1 -> out_data=0x7FFFFFFFFFFFFFFF, out_nv=1; out_fflags_NV=1 the cycle after the pop.
- uint32, sign=1, in_data=0xFFFFFFFFFFFFFFFB, in_flg_NV=0 -> out_data=0, out_nv=1.
- Backpressure: push 3 back-to-back with in_ready=0 -> out_ready=0 after the 2nd push and the 3rd is held upstream. Then in_ready=1 -> results retire in order with no loss or duplication.
- in_fflags_clr and a pop with nv=1 in the same cycle -> out_fflags_NV=1. in_flush at FULL -> out_valid=0 next cycle, out_ready=1. Reset asserted at FULL -> outputs at reset values immediately.
